phy_rx_serial_sync: RTL and testbench

//  Receive-side serial front end of the PHY. Takes the 1-bit lane stream produced by the TX serializer, at one bit per clk_32f.

---
 rtl/phy_rx_serial_sync.sv | 120 ++++++++++++
 tb/tb_phy_rx_serial_sync.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_rx_serial_sync.sv
// Receive-side serial front end of the PHY lane.
// Finds byte alignment from a run of COM symbols in the serial stream.
// After alignment it deserializes the stream, MSB first, into bytes.
// Data bytes go to the demux stage with a one-cycle valid pulse.
// COM and IDLE fill bytes are strobed but are marked invalid.
module phy_rx_serial_sync #(
    parameter logic [7:0] COM_SYM   = 8'hBC,
    parameter logic [7:0] IDLE_SYM  = 8'h7C,
    parameter int         COM_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       rst,
    input  logic       data_in,
    output logic       active,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_strobe
);

    localparam int CNT_W = (COM_COUNT < 2) ? 1 : $clog2(COM_COUNT + 1);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_e;

    state_e             state_r;
    // Only the seven most recent bits are kept. The eighth bit of the
    // window is always the live data_in bit.
    logic [6:0]         sr_r;
    logic [2:0]         bit_cnt_r;
    logic [CNT_W-1:0]   com_cnt_r;

    logic [7:0]         win_s;
    logic               boundary_s;
    logic               is_com_s;
    logic               is_idle_s;
    logic [CNT_W-1:0]   com_next_s;

    // Window = the byte completed by the current bit, plus the compare flags for that byte.
    always_comb begin
        win_s      = {sr_r, data_in};
        boundary_s = (bit_cnt_r == 3'd7);
        is_com_s   = (win_s == COM_SYM);
        is_idle_s  = (win_s == IDLE_SYM);
        com_next_s = com_cnt_r + CNT_W'(1);
    end

    // Alignment FSM, bit counter, shift register and registered byte outputs.
    always_ff @(posedge clk_32f) begin
        if (rst) begin
            state_r     <= ST_SEARCH;
            sr_r        <= 7'd0;
            bit_cnt_r   <= 3'd0;
            com_cnt_r   <= '0;
            data_out    <= 8'd0;
            active      <= 1'b0;
            valid_out   <= 1'b0;
            byte_strobe <= 1'b0;
        end else begin
            sr_r        <= win_s[6:0];
            bit_cnt_r   <= bit_cnt_r + 3'd1;
            byte_strobe <= 1'b0;
            valid_out   <= 1'b0;
            case (state_r)
                ST_SEARCH: begin
                    // Any bit position may start a COM. A hit fixes the byte phase.
                    if (is_com_s) begin
                        com_cnt_r <= CNT_W'(1);
                        bit_cnt_r <= 3'd0;
                        if (COM_COUNT == 1) begin
                            state_r <= ST_ACTIVE;
                            active  <= 1'b1;
                        end else begin
                            state_r <= ST_ALIGN;
                        end
                    end else begin
                        state_r <= ST_SEARCH;
                    end
                end
                ST_ALIGN: begin
                    // Only whole bytes on the locked phase count toward alignment.
                    if (boundary_s) begin
                        if (is_com_s) begin
                            com_cnt_r <= com_next_s;
                            if (com_next_s == CNT_W'(COM_COUNT)) begin
                                state_r <= ST_ACTIVE;
                                active  <= 1'b1;
                            end else begin
                                state_r <= ST_ALIGN;
                            end
                        end else begin
                            state_r   <= ST_SEARCH;
                            com_cnt_r <= '0;
                        end
                    end else begin
                        state_r <= ST_ALIGN;
                    end
                end
                ST_ACTIVE: begin
                    // Present every aligned byte. A COM inside the stream never realigns.
                    if (boundary_s) begin
                        byte_strobe <= 1'b1;
                        data_out    <= win_s;
                        valid_out   <= !(is_com_s || is_idle_s);
                    end else begin
                        byte_strobe <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_SEARCH;
                    com_cnt_r <= '0;
                    active    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phy_rx_serial_sync.sv
// Self-checking bench for phy_rx_serial_sync.
// Two instances share one serial stream: COM_COUNT=4 (index 0) and COM_COUNT=1 (index 1).
// The whole bit/reset stream is built first. Expected outputs for every cycle
// are then computed by scanning that stream for COM runs. The stream is then
// played into the DUTs and the outputs are compared cycle by cycle. Directed
// checks on the scenario milestones are added on top.
module tb_phy_rx_serial_sync;

    localparam logic [7:0] COM  = 8'hBC;
    localparam logic [7:0] IDLE = 8'h7C;
    localparam int         MAXN = 2048;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b0;
    logic       act4, val4, stb4;
    logic [7:0] dat4;
    logic       act1, val1, stb1;
    logic [7:0] dat1;

    always #5 clk = ~clk;

    phy_rx_serial_sync #(.COM_SYM(8'hBC), .IDLE_SYM(8'h7C), .COM_COUNT(4)) u_dut4 (
        .clk_32f(clk), .rst(rst), .data_in(din),
        .active(act4), .data_out(dat4), .valid_out(val4), .byte_strobe(stb4)
    );

    phy_rx_serial_sync #(.COM_SYM(8'hBC), .IDLE_SYM(8'h7C), .COM_COUNT(1)) u_dut1 (
        .clk_32f(clk), .rst(rst), .data_in(din),
        .active(act1), .data_out(dat1), .valid_out(val1), .byte_strobe(stb1)
    );

    logic       q_din[$];
    logic       q_rst[$];
    logic       ex_act [2][MAXN];
    logic       ex_stb [2][MAXN];
    logic       ex_val [2][MAXN];
    logic [7:0] ex_dat [2][MAXN];

    logic [7:0] cap_dat[$];
    logic       cap_val[$];
    int         cap_t[$];

    int checks   = 0;
    int failures = 0;

    task automatic push_bit(input logic b, input logic r);
        q_din.push_back(b);
        q_rst.push_back(r);
    endtask

    task automatic push_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) push_bit(v[i], 1'b0);
    endtask

    task automatic push_rand_bits(input int n);
        for (int i = 0; i < n; i++) push_bit(1'($urandom_range(1, 0)), 1'b0);
    endtask

    task automatic push_rst(input int n);
        for (int i = 0; i < n; i++) push_bit(1'($urandom_range(1, 0)), 1'b1);
    endtask

    // Byte ending at cycle u. Bits before the segment start s read as zero.
    function automatic logic [7:0] window_at(input int u, input int s);
        logic [7:0] w;
        int idx;
        w = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            idx = u - i;
            w = {w[6:0], (idx >= s) ? q_din[idx] : 1'b0};
        end
        return w;
    endfunction

    // Scan each reset-free segment: find a COM, require cc-1 more COMs at
    // 8-bit spacing, then strobe every 8th cycle after the lock point.
    task automatic build_model(input int ci, input int cc);
        int n, t, s, e, p, hit, lock, fail_at, u2;
        logic ok, stb;
        logic [7:0] data;
        n = q_din.size();
        t = 0;
        while (t < n) begin
            if (q_rst[t]) begin
                ex_act[ci][t] = 1'b0; ex_stb[ci][t] = 1'b0;
                ex_val[ci][t] = 1'b0; ex_dat[ci][t] = 8'h00;
                t++;
            end else begin
                s = t;
                e = t;
                while (e < n && !q_rst[e]) e++;
                lock = -1;
                p = s;
                while (lock < 0) begin
                    hit = -1;
                    for (int u = p; u < e; u++) begin
                        if (window_at(u, s) == COM) begin
                            hit = u;
                            break;
                        end
                    end
                    if (hit < 0) break;
                    ok = 1'b1;
                    fail_at = -1;
                    for (int k = 1; k < cc; k++) begin
                        u2 = hit + 8 * k;
                        if (u2 >= e) begin ok = 1'b0; fail_at = e; break; end
                        if (window_at(u2, s) != COM) begin ok = 1'b0; fail_at = u2; break; end
                    end
                    if (ok) lock = hit + 8 * (cc - 1);
                    else p = fail_at + 1;
                end
                data = 8'h00;
                for (int u = s; u < e; u++) begin
                    stb = (lock >= 0) && (u > lock) && ((u - lock) % 8 == 0);
                    if (stb) data = window_at(u, s);
                    ex_act[ci][u] = (lock >= 0) && (u >= lock);
                    ex_stb[ci][u] = stb;
                    ex_val[ci][u] = stb && (data != COM) && (data != IDLE);
                    ex_dat[ci][u] = data;
                end
                t = e;
            end
        end
    endtask

    task automatic check(input string tag, input int t, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s t=%0d got=%h want=%h", tag, t, obs, exp);
        end
    endtask

    initial begin
        int n, t_lock1, t_data, t_fail, t_relock, t_mid, t_mid_relock, t_cc_bc, t_cc_end;
        logic [7:0] exp_seq [4];
        logic       exp_vld [4];
        int         r;
        exp_seq = '{8'hA5, 8'h7C, 8'h3C, 8'hBC};
        exp_vld = '{1'b1, 1'b0, 1'b1, 1'b0};

        // Reset, then lock after junk bits, then the directed data bytes.
        push_rst(3);
        push_rand_bits(3);
        for (int i = 0; i < 4; i++) push_byte(COM);
        t_lock1 = q_din.size() - 1;
        t_data = q_din.size();
        push_byte(8'hA5); push_byte(8'h7C); push_byte(8'h3C); push_byte(8'hBC);
        // Failed lock, then relock.
        push_rst(1);
        for (int i = 0; i < 3; i++) push_byte(COM);
        push_byte(8'h5A);
        t_fail = q_din.size() - 1;
        for (int i = 0; i < 4; i++) push_byte(COM);
        t_relock = q_din.size() - 1;
        // Random payload with frequent fill symbols.
        for (int i = 0; i < 16; i++) begin
            r = int'($urandom_range(3, 0));
            if (r == 0) push_byte(COM);
            else if (r == 1) push_byte(IDLE);
            else push_byte(8'($urandom_range(255, 0)));
        end
        // Reset while bit 4 of an 0xFF byte is on the line, then relock.
        push_byte(8'h11);
        for (int i = 0; i < 4; i++) push_bit(1'b1, 1'b0);
        t_mid = q_din.size();
        push_rst(1);
        for (int i = 0; i < 4; i++) push_byte(COM);
        t_mid_relock = q_din.size() - 1;
        for (int i = 0; i < 6; i++) push_byte(8'($urandom_range(255, 0)));
        // Random bit stream while searching, then lock and data.
        push_rst(1);
        push_rand_bits(40);
        for (int i = 0; i < 4; i++) push_byte(COM);
        for (int i = 0; i < 4; i++) push_byte(8'($urandom_range(255, 0)));
        // Single-COM lock scenario for the COM_COUNT=1 instance.
        push_rst(1);
        push_byte(COM);
        t_cc_bc = q_din.size() - 1;
        push_byte(8'h11);
        t_cc_end = q_din.size() - 1;
        push_byte(8'h00);

        n = q_din.size();
        if (n > MAXN) begin
            $display("FAIL stimulus length %0d exceeds %0d", n, MAXN);
            $fatal(1, "stimulus too long");
        end
        build_model(0, 4);
        build_model(1, 1);

        for (int t = 0; t < n; t++) begin
            rst = q_rst[t];
            din = q_din[t];
            @(posedge clk);
            #1;
            check("act4", t, {7'd0, act4}, {7'd0, ex_act[0][t]});
            check("stb4", t, {7'd0, stb4}, {7'd0, ex_stb[0][t]});
            check("val4", t, {7'd0, val4}, {7'd0, ex_val[0][t]});
            check("dat4", t, dat4, ex_dat[0][t]);
            check("act1", t, {7'd0, act1}, {7'd0, ex_act[1][t]});
            check("stb1", t, {7'd0, stb1}, {7'd0, ex_stb[1][t]});
            check("val1", t, {7'd0, val1}, {7'd0, ex_val[1][t]});
            check("dat1", t, dat1, ex_dat[1][t]);
            if (t == 2) begin
                check("rst_outs4", t, {4'd0, act4, val4, stb4, 1'b0}, 8'h00);
                check("rst_dat4", t, dat4, 8'h00);
            end
            if (t == t_lock1 - 1) check("prelock_act", t, {7'd0, act4}, 8'h00);
            if (t == t_lock1) begin
                check("lock_act", t, {7'd0, act4}, 8'h01);
                check("lock_stb", t, {7'd0, stb4}, 8'h00);
            end
            if (t == t_fail) check("fail_act", t, {7'd0, act4}, 8'h00);
            if (t == t_relock) check("relock_act", t, {7'd0, act4}, 8'h01);
            if (t == t_mid) begin
                check("mid_act", t, {7'd0, act4}, 8'h00);
                check("mid_stb", t, {7'd0, stb4}, 8'h00);
            end
            if (t == t_mid_relock) check("mid_relock_act", t, {7'd0, act4}, 8'h01);
            if (t == t_cc_bc) check("cc1_act", t, {7'd0, act1}, 8'h01);
            if (t == t_cc_end) begin
                check("cc1_dat", t, dat1, 8'h11);
                check("cc1_val", t, {7'd0, val1}, 8'h01);
                check("cc4_act", t, {7'd0, act4}, 8'h00);
            end
            if (stb4 === 1'b1 && t >= t_data && t < t_data + 32) begin
                cap_dat.push_back(dat4);
                cap_val.push_back(val4);
                cap_t.push_back(t);
            end
        end

        check("data_count", 0, 8'(cap_dat.size()), 8'd4);
        for (int i = 0; i < cap_dat.size() && i < 4; i++) begin
            check("data_byte", cap_t[i], cap_dat[i], exp_seq[i]);
            check("data_valid", cap_t[i], {7'd0, cap_val[i]}, {7'd0, exp_vld[i]});
            if (i > 0) check("data_gap", cap_t[i], 8'(cap_t[i] - cap_t[i-1]), 8'd8);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
